ec_rns_fwd_conv: RTL and testbench

- Forward (binary-to-residue) converter; the encoder counterpart of the error-correcting product-sum datapath.
- Datapath output is sign plus four 16-bit binary chunks; this block takes the same sign/4-chunk format and produces one residue per modulus of the redundant RNS.
- Output feeds the data_A / data_B operand FIFO write side.
- Iterative Horner reduction, one 16-bit chunk per cycle, all digits in parallel.

---
 rtl/ec_rns_fwd_conv_if.sv | 35 +++
 rtl/ec_rns_fwd_conv.sv | 126 ++++++++++++
 tb/tb_ec_rns_fwd_conv.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ec_rns_fwd_conv_if.sv
// Handshake/data bundle for the binary-to-residue forward converter.
// Carries the sign/4-chunk input word and the packed residue output.
interface ec_rns_fwd_conv_if #(
  parameter int NUM_DIGITS = 10,
  parameter int DIGIT_W    = 18
);
  logic                          in_valid;
  logic                          in_ready;
  logic                          sign_in;
  logic [15:0]                   bin_in_1_;
  logic [15:0]                   bin_in_2_;
  logic [15:0]                   bin_in_3_;
  logic [15:0]                   bin_in_4_;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_DIGITS*DIGIT_W-1:0] residues_out;

  modport master (
    output in_valid, sign_in,
    output bin_in_1_, bin_in_2_,
    output bin_in_3_, bin_in_4_,
    output out_ready,
    input  in_ready, out_valid,
    input  residues_out
  );

  modport slave (
    input  in_valid, sign_in,
    input  bin_in_1_, bin_in_2_,
    input  bin_in_3_, bin_in_4_,
    input  out_ready,
    output in_ready, out_valid,
    output residues_out
  );
endinterface

// File: rtl/ec_rns_fwd_conv.sv
// Forward converter: sign + 64-bit magnitude -> residues, Horner, MS chunk first.
// Optional single-digit error injection when EC_FWD_ERR_INJ_EN is defined.
module ec_rns_fwd_conv #(
  parameter int NUM_DIGITS = 10,
  parameter int DIGIT_W    = 18,
  parameter int NUM_CHUNKS = 4
) (
  input  logic s_clk,
  input  logic reset_in,
  ec_rns_fwd_conv_if.slave bus,
`ifdef EC_FWD_ERR_INJ_EN
  input  logic       err_inj,
  input  logic [3:0] err_inj_digit,
`endif
  output logic busy
);
  localparam int IDX_W = $clog2(NUM_CHUNKS);
  localparam int ACC_W = DIGIT_W + 16;

  localparam logic [DIGIT_W-1:0] MODS [NUM_DIGITS] = '{
    18'd65536,  18'd78125,  18'd117649,
    18'd177147, 18'd262027, 18'd262049,
    18'd262051, 18'd262069, 18'd262079,
    18'd262103
  };

  typedef enum logic [1:0] {
    IDLE, CONV, SIGN, HOLD
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               sgn;
  logic               out_valid_q;
  logic [15:0]        chunk  [NUM_CHUNKS];
  logic [DIGIT_W-1:0] r      [NUM_DIGITS];
  logic [DIGIT_W-1:0] horner [NUM_DIGITS];
  logic [DIGIT_W-1:0] fixed  [NUM_DIGITS];
  logic [15:0]        cur_chunk;

`ifdef EC_FWD_ERR_INJ_EN
  logic       inj_q;
  logic [3:0] inj_dig_q;
`endif

  assign cur_chunk     = chunk[idx];
  assign bus.in_ready  = (state == IDLE) && !reset_in;
  assign bus.out_valid = out_valid_q;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    logic [ACC_W-1:0]   acc;
    logic [DIGIT_W-1:0] negd;

    assign acc = {r[i], 16'h0000} + ACC_W'(cur_chunk);
    assign horner[i] = DIGIT_W'(acc % ACC_W'(MODS[i]));

    assign negd = (sgn && r[i] != '0) ? MODS[i] - r[i] : r[i];

`ifdef EC_FWD_ERR_INJ_EN
    logic hit;
    assign hit = inj_q && (inj_dig_q == 4'(i));
    assign fixed[i] = !hit ? negd :
                      (negd == MODS[i] - 1'b1) ? '0 :
                      negd + 1'b1;
`else
    assign fixed[i] = negd;
`endif

    assign bus.residues_out[i*DIGIT_W +: DIGIT_W] = r[i];
  end

  // Conversion FSM: accept, reduce one chunk per cycle, negate, hold result.
  always_ff @(posedge s_clk or posedge reset_in) begin
    if (reset_in) begin
      state       <= IDLE;
      idx         <= '0;
      sgn         <= 1'b0;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < NUM_CHUNKS; i++) chunk[i] <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) r[i] <= '0;
`ifdef EC_FWD_ERR_INJ_EN
      inj_q     <= 1'b0;
      inj_dig_q <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sgn      <= bus.sign_in;
            chunk[0] <= bus.bin_in_1_;
            chunk[1] <= bus.bin_in_2_;
            chunk[2] <= bus.bin_in_3_;
            chunk[3] <= bus.bin_in_4_;
`ifdef EC_FWD_ERR_INJ_EN
            inj_q     <= err_inj;
            inj_dig_q <= err_inj_digit;
`endif
            for (int i = 0; i < NUM_DIGITS; i++) r[i] <= '0;
            idx   <= IDX_W'(NUM_CHUNKS - 1);
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          for (int i = 0; i < NUM_DIGITS; i++) r[i] <= horner[i];
          idx <= idx - IDX_W'(1);
          if (idx == '0) state <= SIGN;
        end
        SIGN: begin
          for (int i = 0; i < NUM_DIGITS; i++) r[i] <= fixed[i];
          out_valid_q <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ec_rns_fwd_conv.sv
// Randomized self-checking bench for ec_rns_fwd_conv.
// Reference residues come from direct 64-bit modulo arithmetic.
module tb_ec_rns_fwd_conv;
  localparam int ND = 10;
  localparam int DW = 18;
  localparam int unsigned MODS [ND] = '{
    65536, 78125, 117649, 177147, 262027,
    262049, 262051, 262069, 262079, 262103
  };

  logic s_clk = 1'b0;
  logic reset_in = 1'b1;
  logic busy;

  ec_rns_fwd_conv_if #(.NUM_DIGITS(ND), .DIGIT_W(DW)) bus ();

`ifdef EC_FWD_ERR_INJ_EN
  logic       err_inj = 1'b0;
  logic [3:0] err_inj_digit = 4'd0;
`endif

  ec_rns_fwd_conv dut (
    .s_clk         (s_clk),
    .reset_in      (reset_in),
    .bus           (bus),
`ifdef EC_FWD_ERR_INJ_EN
    .err_inj       (err_inj),
    .err_inj_digit (err_inj_digit),
`endif
    .busy          (busy)
  );

  always #5 s_clk = ~s_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(int i, bit s,
                                          logic [63:0] mag,
                                          bit inj, int d);
    longint unsigned m = longint'(MODS[i]);
    longint unsigned v = mag % m;
    if (s && v != 0) v = m - v;
    if (inj && d == i) v = (v + 1) % m;
    return v;
  endfunction

  task automatic check_res(string tag, bit s, logic [63:0] mag,
                           bit inj, int d);
    for (int i = 0; i < ND; i++)
      chk($sformatf("%s_d%0d", tag, i),
          64'(bus.residues_out[i*DW +: DW]),
          ref_res(i, s, mag, inj, d));
  endtask

  task automatic convert(string tag, bit s, logic [63:0] mag,
                         bit inj, int d, int hold, bit poke);
    int cyc;
    logic [ND*DW-1:0] snap;
    cyc = 0;
    while (!bus.in_ready && cyc < 20) begin
      @(posedge s_clk); #1; cyc++;
    end
    chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
    bus.sign_in   = s;
    bus.bin_in_1_ = mag[15:0];
    bus.bin_in_2_ = mag[31:16];
    bus.bin_in_3_ = mag[47:32];
    bus.bin_in_4_ = mag[63:48];
`ifdef EC_FWD_ERR_INJ_EN
    err_inj       = inj;
    err_inj_digit = 4'(d);
`endif
    bus.in_valid = 1'b1;
    @(posedge s_clk); #1;
    bus.in_valid  = 1'b0;
    bus.sign_in   = 1'($urandom);
    bus.bin_in_1_ = 16'($urandom);
    bus.bin_in_2_ = 16'($urandom);
    bus.bin_in_3_ = 16'($urandom);
    bus.bin_in_4_ = 16'($urandom);
`ifdef EC_FWD_ERR_INJ_EN
    err_inj       = 1'($urandom);
    err_inj_digit = 4'($urandom);
`endif
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_nrdy"}, 64'(bus.in_ready), 64'd0);
    cyc = 0;
    while (!bus.out_valid && cyc < 10) begin
      @(posedge s_clk); #1; cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'd5);
    check_res(tag, s, mag, inj, d);
    snap = bus.residues_out;
    if (poke) bus.in_valid = 1'b1;
    repeat (hold) begin
      @(posedge s_clk); #1;
      chk({tag, "_stable"}, 64'(bus.residues_out == snap), 64'd1);
      chk({tag, "_hold_nrdy"}, 64'(bus.in_ready), 64'd0);
      chk({tag, "_hold_ov"}, 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge s_clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_ov_fall"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_rdy_back"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] mag;
    bit s;
    bit inj;
    int d;
    int cyc;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sign_in   = 1'b0;
    bus.bin_in_1_ = '0;
    bus.bin_in_2_ = '0;
    bus.bin_in_3_ = '0;
    bus.bin_in_4_ = '0;

    #1;
    chk("rst_rdy", 64'(bus.in_ready), 64'd0);
    chk("rst_ov", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res0", 64'(bus.residues_out == '0), 64'd1);
    repeat (2) @(posedge s_clk);
    #1 reset_in = 1'b0;
    #1;
    chk("post_rst_rdy", 64'(bus.in_ready), 64'd1);

    convert("p1", 1'b0, 64'd1, 1'b0, 0, 0, 1'b0);
    convert("m1", 1'b1, 64'd1, 1'b0, 0, 1, 1'b0);
    convert("p2e32", 1'b0, 64'h1_0000_0000, 1'b0, 0, 0, 1'b0);
    chk("p2e32_d1", 64'(bus.residues_out[DW +: DW]), 64'd45421);
    convert("m0", 1'b1, 64'd0, 1'b0, 0, 0, 1'b0);
    convert("max", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 0, 1'b0);
    convert("hold", 1'b0, 64'd123456789, 1'b0, 0, 5, 1'b1);
    convert("after", 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 0, 1'b0);

    bus.sign_in   = 1'b0;
    bus.bin_in_1_ = 16'h1234;
    bus.bin_in_2_ = 16'h5678;
    bus.bin_in_3_ = 16'h0;
    bus.bin_in_4_ = 16'h0;
    bus.in_valid  = 1'b1;
    @(posedge s_clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge s_clk);
    #1 reset_in = 1'b1;
    #1;
    chk("abort_ov", 64'(bus.out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rdy", 64'(bus.in_ready), 64'd0);
    @(posedge s_clk);
    #1 reset_in = 1'b0;
    #1;
    chk("abort_rdy_back", 64'(bus.in_ready), 64'd1);
    cyc = 0;
    repeat (6) begin
      @(posedge s_clk); #1;
      if (bus.out_valid) cyc++;
    end
    chk("abort_no_out", 64'(cyc), 64'd0);
    convert("p7", 1'b0, 64'd7, 1'b0, 0, 0, 1'b0);

`ifdef EC_FWD_ERR_INJ_EN
    convert("inj3", 1'b0, 64'd5, 1'b1, 3, 0, 1'b0);
    chk("inj3_d3", 64'(bus.residues_out[3*DW +: DW]), 64'd6);
    convert("inj15", 1'b0, 64'd5, 1'b1, 15, 0, 1'b0);
    convert("injwrap", 1'b1, 64'd1, 1'b1, 0, 0, 1'b0);
    chk("injwrap_d0", 64'(bus.residues_out[DW-1:0]), 64'd0);
`endif

    for (int k = 0; k < 40; k++) begin
      mag = {32'($urandom), 32'($urandom)};
      case ($urandom_range(0, 3))
        0: mag[63:32] = '0;
        1: mag[47:0] = '0;
        default: ;
      endcase
      s   = 1'($urandom);
      inj = 1'b0;
      d   = 0;
`ifdef EC_FWD_ERR_INJ_EN
      inj = 1'($urandom);
      d   = int'($urandom_range(0, 15));
`endif
      convert($sformatf("rnd%0d", k), s, mag, inj, d,
              int'($urandom_range(0, 3)), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge s_clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
